instruction_queue_register: RTL

Parametrised successor to the single-entry instruction register: a DEPTH-entry prefetch FIFO feeding a current-instruction register (IR) with decoded field outputs. Sits between instruction memory and the control unit. Memory pushes fetched words; the control unit advances the IR with InstWrite and discards prefetched words with Flush on a taken branch. Width and field positions are parameters, so the 16-bit ISA is only one configuration.

---
 rtl/instruction_queue_register.sv | 103 ++++++++++
 1 files changed

// File: rtl/instruction_queue_register.sv
// Prefetch FIFO feeding a current-instruction register with decoded field outputs.
// Memory pushes fetched words; the control unit advances the IR and flushes on taken branches.
module instruction_queue_register #(
  parameter int INST_W = 16,
  parameter int OP_W   = 4,
  parameter int REG_W  = 4,
  parameter int IMM_W  = 8,
  parameter int DEPTH  = 4
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [INST_W-1:0] DataIn,
  input  logic              InstValid,
  output logic              InstReady,
  input  logic              InstWrite,
  input  logic              Flush,
  output logic [INST_W-1:0] DataOut,
  output logic [OP_W-1:0]   Op,
  output logic [REG_W-1:0]  Rd,
  output logic [REG_W-1:0]  Rm,
  output logic [IMM_W-1:0]  Imm,
  output logic              CurValid,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic              Empty,
  output logic              Full,
  output logic              Overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [INST_W-1:0] queueMem [DEPTH];
  logic [PTR_W-1:0]  rdPtr;
  logic [PTR_W-1:0]  wrPtr;

  logic pushOk;
  logic pushDrop;
  logic popFifo;
  logic bypass;
  logic pushFifo;

  // Status flags come from the registered count only, never from same-cycle inputs.
  assign Empty     = (Count == '0);
  assign Full      = (Count == CNT_W'(DEPTH));
  assign InstReady = !Full;

  assign pushOk   = InstValid && !Full;
  assign pushDrop = InstValid && Full;
  assign popFifo  = InstWrite && !Empty;
  assign bypass   = InstWrite && Empty && pushOk;
  assign pushFifo = pushOk && !bypass;

  assign Op  = DataOut[INST_W-1 -: OP_W];
  assign Rd  = DataOut[INST_W-OP_W-1 -: REG_W];
  assign Rm  = DataOut[INST_W-OP_W-REG_W-1 -: REG_W];
  assign Imm = DataOut[IMM_W-1:0];

  // Storage array carries data only, so it is left out of reset.
  always_ff @(posedge CLK) begin
    if (!Reset && !Flush && pushFifo) begin
      queueMem[wrPtr] <= DataIn;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      Count    <= '0;
      DataOut  <= '0;
      CurValid <= 1'b0;
      Overflow <= 1'b0;
    end else if (Flush) begin
      // The branch sitting in the IR is still executing, so IR and CurValid hold.
      rdPtr <= '0;
      wrPtr <= '0;
      Count <= '0;
    end else begin
      if (pushFifo) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (popFifo) begin
        rdPtr    <= rdPtr + PTR_W'(1);
        DataOut  <= queueMem[rdPtr];
        CurValid <= 1'b1;
      end else if (bypass) begin
        DataOut  <= DataIn;
        CurValid <= 1'b1;
      end else if (InstWrite) begin
        CurValid <= 1'b0;
      end
      if (pushFifo && !popFifo) begin
        Count <= Count + CNT_W'(1);
      end else if (!pushFifo && popFifo) begin
        Count <= Count - CNT_W'(1);
      end
      if (pushDrop) begin
        Overflow <= 1'b1;
      end
    end
  end

endmodule
